// File: rtl/branch_predictor_pkg.sv
// ============================================================================
// Module      : branch_predictor_pkg
// Description : Shared CPU helpers used by the IF/ID stages: PC field
//               extraction and saturating-counter arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package branch_predictor_pkg;

   localparam int unsigned c_maxCtrW = 4;
   localparam int unsigned c_pcW     = 32;

   // Word-aligned index field: pc[idxW+1:2], right-justified.
   function automatic logic [c_pcW-1:0] pcIndex(input logic [c_pcW-1:0] pc,
                                                input int unsigned     idxW);
      return (pc >> 2) & ((32'd1 << idxW) - 32'd1);
   endfunction

   function automatic logic [c_pcW-1:0] pcTag(input logic [c_pcW-1:0] pc,
                                              input int unsigned     idxW,
                                              input int unsigned     tagW);
      return (pc >> (idxW + 2)) & ((32'd1 << tagW) - 32'd1);
   endfunction

   function automatic logic [c_maxCtrW-1:0] weaklyTaken(input int unsigned ctrW);
      return c_maxCtrW'(32'd1 << (ctrW - 1));
   endfunction

   function automatic logic [c_maxCtrW-1:0] ctrNext(input logic [c_maxCtrW-1:0] ctr,
                                                    input logic                 taken,
                                                    input int unsigned          ctrW);
      logic [c_maxCtrW-1:0] maxVal;
      maxVal = c_maxCtrW'((32'd1 << ctrW) - 32'd1);
      if (taken)
         return (ctr == maxVal) ? ctr : ctr + 4'd1;
      else
         return (ctr == 4'd0) ? ctr : ctr - 4'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/branch_predictor.sv
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped tagged branch target buffer with per-entry
//               saturating direction counters and event statistics.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int unsigned ENTRIES = 64,
   parameter int unsigned CTR_W   = 2,
   parameter int unsigned TAG_W   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] lookup_pc,
   output logic        pred_hit,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic        upd_mispredict,
   input  logic        flush_all,
   output logic [31:0] stat_branches,
   output logic [31:0] stat_mispredicts
);

   localparam int unsigned c_idxW = $clog2(ENTRIES);

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [CTR_W-1:0] ctr;
      logic [31:0]      target;
   } entry_t;

   localparam logic [CTR_W-1:0] c_ctrInit = CTR_W'(weaklyTaken(CTR_W));

   entry_t      r_table [ENTRIES];
   logic [31:0] r_statBranches;
   logic [31:0] r_statMispredicts;

   logic [c_idxW-1:0] w_lkIdx;
   logic [TAG_W-1:0]  w_lkTag;
   entry_t            w_lkEntry;
   logic              w_lkHit;
   logic [c_idxW-1:0] w_updIdx;
   logic [TAG_W-1:0]  w_updTag;
   entry_t            w_updEntry;
   logic              w_updHit;
   logic [CTR_W-1:0]  w_updCtrNext;

   assign w_lkIdx   = c_idxW'(pcIndex(lookup_pc, c_idxW));
   assign w_lkTag   = TAG_W'(pcTag(lookup_pc, c_idxW, TAG_W));
   assign w_lkEntry = r_table[w_lkIdx];
   assign w_lkHit   = w_lkEntry.valid && (w_lkEntry.tag == w_lkTag);

   assign pred_hit    = w_lkHit;
   assign pred_taken  = w_lkHit && w_lkEntry.ctr[CTR_W-1];
   assign pred_target = w_lkHit ? w_lkEntry.target : 32'd0;

   assign w_updIdx     = c_idxW'(pcIndex(upd_pc, c_idxW));
   assign w_updTag     = TAG_W'(pcTag(upd_pc, c_idxW, TAG_W));
   assign w_updEntry   = r_table[w_updIdx];
   assign w_updHit     = w_updEntry.valid && (w_updEntry.tag == w_updTag);
   assign w_updCtrNext = CTR_W'(ctrNext(c_maxCtrW'(w_updEntry.ctr), upd_taken, CTR_W));

   // Flush wins over a same-edge update; statistics still count that update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(ENTRIES); i++) r_table[i] <= '0;
         r_statBranches    <= '0;
         r_statMispredicts <= '0;
      end else begin
         if (upd_valid) begin
            if (r_statBranches != '1) r_statBranches <= r_statBranches + 32'd1;
            if (upd_mispredict && (r_statMispredicts != '1))
               r_statMispredicts <= r_statMispredicts + 32'd1;
         end
         if (flush_all) begin
            for (int i = 0; i < int'(ENTRIES); i++) r_table[i].valid <= 1'b0;
         end else if (upd_valid) begin
            if (w_updHit) begin
               r_table[w_updIdx].ctr <= w_updCtrNext;
               if (upd_taken) r_table[w_updIdx].target <= upd_target;
            end else if (upd_taken) begin
               r_table[w_updIdx] <= '{valid: 1'b1, tag: w_updTag, ctr: c_ctrInit,
                                      target: upd_target};
            end
         end
      end
   end

   assign stat_branches    = r_statBranches;
   assign stat_mispredicts = r_statMispredicts;

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// ============================================================================
// Module      : tb_branch_predictor
// Description : Self-checking bench for branch_predictor against a table model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_predictor;

   localparam int ENTRIES = 64;
   localparam int CTR_MAX = 3;
   localparam int CTR_INIT = 2;
   localparam int TAG_MOD = 256;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] lookup_pc = '0;
   logic        pred_hit, pred_taken;
   logic [31:0] pred_target;
   logic        upd_valid = 1'b0;
   logic [31:0] upd_pc = '0;
   logic        upd_taken = 1'b0;
   logic [31:0] upd_target = '0;
   logic        upd_mispredict = 1'b0;
   logic        flush_all = 1'b0;
   logic [31:0] stat_branches, stat_mispredicts;

   int checks = 0;
   int errors = 0;

   // Reference model: one slot per index, integers for everything.
   bit          mValid [ENTRIES];
   int          mTag   [ENTRIES];
   int          mCtr   [ENTRIES];
   logic [31:0] mTarget[ENTRIES];
   longint      mBr, mMis;

   branch_predictor #(.ENTRIES(64), .CTR_W(2), .TAG_W(8)) dut (
      .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
      .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .upd_target(upd_target), .upd_mispredict(upd_mispredict),
      .flush_all(flush_all), .stat_branches(stat_branches),
      .stat_mispredicts(stat_mispredicts)
   );

   always #5 clk = ~clk;

   function automatic int idxOf(input logic [31:0] pc);
      return int'((pc / 4) % ENTRIES);
   endfunction

   function automatic int tagOf(input logic [31:0] pc);
      return int'((pc / (4 * ENTRIES)) % TAG_MOD);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < ENTRIES; i++) begin
         mValid[i] = 1'b0;
         mCtr[i]   = 0;
      end
      mBr  = 0;
      mMis = 0;
   endtask

   task automatic checkPred(input string tag);
      int  i;
      bit  hit;
      i   = idxOf(lookup_pc);
      hit = mValid[i] && (mTag[i] == tagOf(lookup_pc));
      chk({tag, ".hit"}, 32'(pred_hit), 32'(hit));
      chk({tag, ".taken"}, 32'(pred_taken), 32'(hit && (mCtr[i] >= CTR_INIT)));
      chk({tag, ".target"}, pred_target, hit ? mTarget[i] : 32'd0);
   endtask

   task automatic checkStats(input string tag);
      chk({tag, ".branches"}, stat_branches, 32'(mBr));
      chk({tag, ".mispredicts"}, stat_mispredicts, 32'(mMis));
   endtask

   task automatic modelEdge();
      int i;
      if (rst) return;
      if (upd_valid) begin
         if (mBr < 64'hFFFFFFFF) mBr++;
         if (upd_mispredict && mMis < 64'hFFFFFFFF) mMis++;
      end
      if (flush_all) begin
         for (int k = 0; k < ENTRIES; k++) mValid[k] = 1'b0;
      end else if (upd_valid) begin
         i = idxOf(upd_pc);
         if (mValid[i] && mTag[i] == tagOf(upd_pc)) begin
            mCtr[i] = upd_taken ? ((mCtr[i] + 1 > CTR_MAX) ? CTR_MAX : mCtr[i] + 1)
                                : ((mCtr[i] - 1 < 0) ? 0 : mCtr[i] - 1);
            if (upd_taken) mTarget[i] = upd_target;
         end else if (upd_taken) begin
            mValid[i]  = 1'b1;
            mTag[i]    = tagOf(upd_pc);
            mCtr[i]    = CTR_INIT;
            mTarget[i] = upd_target;
         end
      end
   endtask

   // Called just after a rising edge; ends just after the next one.
   task automatic doCycle(input logic [31:0] lpc, input logic uv, input logic [31:0] upc,
                          input logic ut, input logic [31:0] utgt, input logic um,
                          input logic fl, input string tag);
      lookup_pc      = lpc;
      upd_valid      = uv;
      upd_pc         = upc;
      upd_taken      = ut;
      upd_target     = utgt;
      upd_mispredict = um;
      flush_all      = fl;
      #1;
      checkPred(tag);
      @(posedge clk);
      modelEdge();
      #1;
      checkStats(tag);
      upd_valid = 1'b0;
      flush_all = 1'b0;
   endtask

   initial begin
      logic [31:0] pc, lpc;
      modelReset();

      // Reset state
      lookup_pc = 32'h40;
      #1;
      chk("rst.hit", 32'(pred_hit), 32'd0);
      chk("rst.taken", 32'(pred_taken), 32'd0);
      chk("rst.target", pred_target, 32'd0);
      checkStats("rst");
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Allocation then hit
      doCycle(32'h40, 1, 32'h40, 1, 32'h100, 0, 0, "alloc");
      doCycle(32'h40, 0, 0, 0, 0, 0, 0, "allocHit");
      chk("alloc.const.target", pred_target, 32'h100);
      chk("alloc.const.taken", 32'(pred_taken), 32'd1);

      // Counter saturation both ways
      for (int k = 0; k < 3; k++) doCycle(32'h40, 1, 32'h40, 0, 0, 0, 0, "ntk");
      doCycle(32'h40, 0, 0, 0, 0, 0, 0, "ntkLow");
      chk("ntk.const.taken", 32'(pred_taken), 32'd0);
      for (int k = 0; k < 2; k++) doCycle(32'h40, 1, 32'h40, 1, 32'h104, 0, 0, "tk");
      doCycle(32'h40, 0, 0, 0, 0, 0, 0, "tkMid");
      chk("tk.const.taken", 32'(pred_taken), 32'd1);
      for (int k = 0; k < 6; k++) doCycle(32'h40, 1, 32'h40, 1, 32'h108, 0, 0, "tkSat");
      doCycle(32'h40, 1, 32'h40, 0, 0, 0, 0, "tkSatDown");
      doCycle(32'h40, 0, 0, 0, 0, 0, 0, "tkSatCheck");
      chk("tkSat.const.taken", 32'(pred_taken), 32'd1);

      // Aliasing: same index, different tag
      doCycle(32'h40, 1, 32'h140, 1, 32'h200, 0, 0, "alias");
      doCycle(32'h40, 0, 0, 0, 0, 0, 0, "aliasOld");
      chk("alias.const.oldHit", 32'(pred_hit), 32'd0);
      doCycle(32'h140, 0, 0, 0, 0, 0, 0, "aliasNew");
      chk("alias.const.newTarget", pred_target, 32'h200);

      // No bypass, then flush beats update
      doCycle(32'h80, 1, 32'h80, 1, 32'h300, 0, 0, "sameCyc");
      doCycle(32'h80, 0, 0, 0, 0, 0, 0, "sameCycNext");
      chk("sameCyc.const.hitNext", 32'(pred_hit), 32'd1);
      doCycle(32'h80, 1, 32'hC0, 1, 32'h400, 1, 1, "flushUpd");
      doCycle(32'hC0, 0, 0, 0, 0, 0, 0, "flushC0");
      doCycle(32'h80, 0, 0, 0, 0, 0, 0, "flush80");
      doCycle(32'h140, 0, 0, 0, 0, 0, 0, "flush140");
      chk("flush.const.hit", 32'(pred_hit), 32'd0);

      // Randomized traffic over a small PC pool so entries collide and hit
      for (int n = 0; n < 400; n++) begin
         pc  = ((32'($urandom_range(0, 3)) * ENTRIES) + 32'($urandom_range(0, 7))) * 4;
         lpc = ($urandom_range(0, 9) == 0) ? $urandom
               : ((32'($urandom_range(0, 3)) * ENTRIES) + 32'($urandom_range(0, 7))) * 4;
         doCycle(lpc, 1'($urandom), pc, 1'($urandom), $urandom, 1'($urandom),
                 $urandom_range(0, 39) == 0, "rand");
      end

      // Statistics across flush and asynchronous reset
      #2;
      rst = 1'b1;
      #1;
      modelReset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 10; k++)
         doCycle(32'h40, 1, 32'(k * 4), 1, 32'h500 + 32'(k), k < 4, 0, "stat");
      chk("stat.const.branches", stat_branches, 32'd10);
      chk("stat.const.mispredicts", stat_mispredicts, 32'd4);
      doCycle(32'h0, 0, 0, 0, 0, 1, 1, "statFlush");
      chk("statFlush.const.branches", stat_branches, 32'd10);
      chk("statFlush.const.mispredicts", stat_mispredicts, 32'd4);
      doCycle(32'h40, 1, 32'h40, 1, 32'h600, 0, 0, "preRst");
      doCycle(32'h40, 0, 0, 0, 0, 0, 0, "preRstHit");
      chk("preRst.const.hit", 32'(pred_hit), 32'd1);

      // Mid-cycle reset acts immediately; an update on a reset edge is dropped
      #2;
      upd_valid  = 1'b1;
      upd_pc     = 32'h44;
      upd_taken  = 1'b1;
      upd_target = 32'h700;
      rst        = 1'b1;
      #1;
      modelReset();
      chk("asyncRst.branches", stat_branches, 32'd0);
      chk("asyncRst.mispredicts", stat_mispredicts, 32'd0);
      chk("asyncRst.hit", 32'(pred_hit), 32'd0);
      chk("asyncRst.target", pred_target, 32'd0);
      @(posedge clk);
      modelEdge();
      #1;
      rst       = 1'b0;
      upd_valid = 1'b0;
      doCycle(32'h44, 0, 0, 0, 0, 0, 0, "rstDrop");
      chk("rstDrop.const.hit", 32'(pred_hit), 32'd0);
      checkStats("rstDrop");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 64, number of table entries (power of two, 4..1024).
REQ-002 SHALL have parameter CTR_W, default 2, saturating counter width (1..4).
REQ-003 SHALL have parameter TAG_W, default 8, stored tag width (1..20).
REQ-004 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port lookup_pc  input  32  PC of the instruction being fetched (IF stage).
REQ-007 SHALL have port pred_hit  output  1  valid entry with matching tag exists for lookup_pc.
REQ-008 SHALL have port pred_taken  output  1  predict taken.
REQ-009 SHALL have port pred_target  output  32  predicted target; 0 when pred_hit=0.
REQ-010 SHALL have port upd_valid  input  1  a resolved branch is presented this cycle (ID stage).
REQ-011 SHALL have port upd_pc  input  32  PC of the resolved branch.
REQ-012 SHALL have port upd_taken  input  1  actual outcome.
REQ-013 SHALL have port upd_target  input  32  actual target (PCBranch).
REQ-014 SHALL have port upd_mispredict  input  1  pipeline flushed because the prediction was wrong.
REQ-015 SHALL have port flush_all  input  1  synchronous invalidate of every entry.
REQ-016 SHALL have ports stat_branches and stat_mispredicts  output  32 each  event counters.

Function
REQ-017 SHALL form index = pc[IDX_W+1:2] with IDX_W = log2(ENTRIES) and tag = pc[IDX_W+TAG_W+1:IDX_W+2].
REQ-018 SHALL produce pred_* combinationally from lookup_pc and registered table state (zero-cycle latency).
REQ-019 SHALL assert pred_hit when the entry at the index is valid and its tag equals the lookup tag.
REQ-020 SHALL assert pred_taken only when pred_hit=1 and the counter MSB is 1.
REQ-021 SHALL, on upd_valid with hit, increment the counter when upd_taken=1, saturating at 2^CTR_W-1, else decrement, saturating at 0.
REQ-022 SHALL, on upd_valid with hit and upd_taken=1, write upd_target into the entry.
REQ-023 SHALL, on upd_valid with miss and upd_taken=1, allocate the entry (overwriting any other tag): valid=1, new tag, target=upd_target, counter=2^(CTR_W-1).
REQ-024 SHALL NOT allocate on upd_valid with a miss and upd_taken=0.
REQ-025 SHALL present lookup results from pre-edge state when lookup and update target the same index in the same cycle (no write-to-read bypass).
REQ-026 SHALL clear all valid bits on the edge where flush_all=1; flush_all takes priority over a simultaneous update, which is discarded.
REQ-027 SHALL increment stat_branches on every upd_valid and stat_mispredicts on every upd_valid with upd_mispredict=1, both saturating at 32'hFFFFFFFF; counters are unaffected by flush_all.
REQ-028 SHALL ignore upd_mispredict and upd_taken when upd_valid=0.

Reset
REQ-029 SHALL, while rst=1, clear every valid bit, both stat counters and every counter field, regardless of clk.
REQ-030 SHALL drive pred_hit=0, pred_taken=0, pred_target=0, stat_branches=0 and stat_mispredicts=0 during reset.
REQ-031 SHALL need no reset on tag and target arrays; they are never observable while their entry is invalid.
REQ-032 SHALL discard an update whose edge coincides with rst=1, including rst asserted mid-sequence.

Structure
REQ-033 SHALL place the counter-update function, the weakly-taken init constant and the PC index/tag field helpers in the shared CPU package used by the IF/ID stages.
REQ-034 SHALL contain no sub-module; the table is one flat register array of {valid, tag, counter, target}.

Verification
REQ-035 Reset, then lookup_pc=0x40 -> pred_hit=0, pred_taken=0, pred_target=0.
REQ-036 Update pc=0x40, taken=1, target=0x100; next cycle lookup 0x40 -> hit=1, taken=1 (ctr=2), target=0x100.
REQ-037 From REQ-036, three not-taken updates -> ctr 1, 0, 0 (saturated); pred_taken=0 after the first; two taken updates -> ctr 2 with pred_taken=1; with CTR_W=2, six taken updates -> ctr stays 3.
REQ-038 Alias: with ENTRIES=64, taken update pc=0x40, then taken update pc=0x140 (same index, different tag) -> lookup 0x40 miss, 0x140 hit, target updated.
REQ-039 Same-cycle lookup and allocating update of 0x80 -> pred_hit=0 that cycle, pred_hit=1 the next; flush_all together with an update -> all misses afterwards.
REQ-040 Ten upd_valid, four with upd_mispredict, then flush_all, then rst mid-run -> stat 10/4 retained over the flush, 0/0 immediately on rst assertion without a clock edge.
